// File: rtl/ahb_slave_arbiter.sv
// ahb_slave_arbiter: per-slave AHB arbiter.
// Shares one slave port among SLAVE_X_MASTER_NUM masters using a round-robin scheme.
// Ownership is handed over only on hready. The block also tracks the data-phase
// owner for the slave-side read/write data multiplexers.
// Optional feature: define ARB_HOLD_LIMIT_EN to preempt an owner once it has
// had HOLD_LIMIT transfers accepted while another master is waiting.
module ahb_slave_arbiter #(
    parameter int SLAVE_X_MASTER_NUM = 4,
    parameter int HOLD_LIMIT         = 16,
    parameter int MIDX_W             = $clog2(SLAVE_X_MASTER_NUM)
) (
    input  logic                                hclk,
    input  logic                                hreset,
    input  logic [SLAVE_X_MASTER_NUM-1:0]       hreq,
    input  logic [SLAVE_X_MASTER_NUM-1:0][1:0]  htrans_m,
    input  logic                                hready,
    output logic [SLAVE_X_MASTER_NUM-1:0]       hgrant,
    output logic [MIDX_W-1:0]                   hmaster,
    output logic [MIDX_W-1:0]                   hmaster_data,
    output logic                                hsel
);

    localparam int N = SLAVE_X_MASTER_NUM;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_OWN  = 1'b1;

    localparam logic [N-1:0]      GRANT_ONE  = N'(1);
    localparam logic [MIDX_W-1:0] LAST_RESET = MIDX_W'(N - 1);

    if (SLAVE_X_MASTER_NUM < 2 || HOLD_LIMIT < 1) begin : g_param_check
        $error("ahb_slave_arbiter: needs at least 2 masters and a positive HOLD_LIMIT");
    end

    logic [0:0]        state;
    logic [MIDX_W-1:0] last_owner;

    logic              own_req;
    logic [1:0]        own_trans;
    logic [N-1:0]      others;
    logic [N-1:0]      search;
    logic [MIDX_W:0]   pick;
    logic              rel_ab;
    logic              rel_c;
    logic              do_release;

    // Round-robin search: first set request bit after 'last', wrapping around.
    // Walking from the farthest candidate to the nearest lets the nearest win.
    function automatic logic [MIDX_W:0] rr_pick(input logic [N-1:0] req,
                                                input logic [MIDX_W-1:0] last);
        logic [MIDX_W:0] res;
        int idx;
        res = '0;
        for (int i = N; i >= 1; i--) begin
            idx = (int'(last) + i) % N;
            if (req[MIDX_W'(idx)]) begin
                res = {1'b1, MIDX_W'(idx)};
            end
        end
        return res;
    endfunction

`ifdef ARB_HOLD_LIMIT_EN
    localparam int CNT_W = $clog2(HOLD_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_LIMIT);

    logic [CNT_W-1:0] cnt;
    logic             xfer;
`endif

    // Owner status, release causes and the next round-robin candidate
    always_comb begin
        own_req         = hreq[hmaster];
        own_trans       = htrans_m[hmaster];
        others          = hreq;
        others[hmaster] = 1'b0;
        search          = (state == ARB_IDLE) ? hreq : others;
        pick            = rr_pick(search, last_owner);
        rel_ab          = !own_req || (own_trans == HTRANS_IDLE);
`ifdef ARB_HOLD_LIMIT_EN
        xfer            = own_trans[1];
        rel_c           = (cnt == CNT_MAX) && (|others);
`else
        rel_c           = 1'b0;
`endif
        do_release      = rel_ab || rel_c;
    end

    // Grant state machine and data-phase owner tracking
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state        <= ARB_IDLE;
            hgrant       <= '0;
            hmaster      <= '0;
            hmaster_data <= '0;
            hsel         <= 1'b0;
            last_owner   <= LAST_RESET;
        end else begin
            if (hready) begin
                hmaster_data <= hmaster;
            end
            case (state)
                ARB_IDLE: begin
                    if (pick[MIDX_W]) begin
                        hgrant     <= GRANT_ONE << pick[MIDX_W-1:0];
                        hmaster    <= pick[MIDX_W-1:0];
                        last_owner <= pick[MIDX_W-1:0];
                        hsel       <= 1'b1;
                        state      <= ARB_OWN;
                    end
                end
                default: begin
                    if (hready && do_release) begin
                        if (pick[MIDX_W]) begin
                            hgrant     <= GRANT_ONE << pick[MIDX_W-1:0];
                            hmaster    <= pick[MIDX_W-1:0];
                            last_owner <= pick[MIDX_W-1:0];
                        end else begin
                            hgrant <= '0;
                            hsel   <= 1'b0;
                            state  <= ARB_IDLE;
                        end
                    end
                end
            endcase
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    // Accepted-transfer counter of the current owner; restarts on every grant change
    always_ff @(posedge hclk) begin
        if (hreset) begin
            cnt <= '0;
        end else if (state == ARB_IDLE) begin
            cnt <= '0;
        end else if (hready) begin
            if (do_release || cnt == CNT_MAX) begin
                cnt <= '0;
            end else if (xfer) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`endif

endmodule
